// File: rtl/pwm_cfg_sequencer.sv
// pwm_cfg_sequencer: buffers decoded register writes in a FIFO and applies them
// to the active PWM configuration atomically on a period boundary.
module pwm_cfg_sequencer #(
    parameter int NCH   = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [3:0]        wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              period_end,
    input  logic              clr_err,
    output logic [DW-1:0]     cfg_period,
    output logic [NCH*DW-1:0] cfg_duty,
    output logic [NCH-1:0]    cfg_en,
    output logic              commit,
    output logic              busy,
    output logic              err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t              state_q;
    logic [3:0]          addr_mem [DEPTH];
    logic [DW-1:0]       data_mem [DEPTH];
    logic [AW:0]         wptr_q, rptr_q;
    logic                dirty_q, err_q, err_d, commit_q;
    logic [DW-1:0]       sh_period_q, period_q;
    logic [NCH-1:0]      sh_en_q, en_q;
    logic [NCH*DW-1:0]   sh_duty_q, duty_q;
    logic                empty, full, push, pop, is_data;
    logic [3:0]          pop_addr;
    logic [DW-1:0]       pop_data;

    assign empty    = wptr_q == rptr_q;
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign pop      = (state_q == IDLE) && !empty;
    assign pop_addr = addr_mem[rptr_q[AW-1:0]];
    assign pop_data = data_mem[rptr_q[AW-1:0]];
    assign is_data  = pop_addr <= 4'(NCH + 1);
    // a new invalid drain outranks a simultaneous clear
    assign err_d    = (pop && !is_data && pop_addr != 4'hF) || (err_q && !clr_err);

    assign cfg_period = period_q;
    assign cfg_duty   = duty_q;
    assign cfg_en     = en_q;
    assign commit     = commit_q;
    assign err        = err_q;
    assign busy       = !empty || state_q != IDLE;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wptr_q[AW-1:0]] <= wr_addr;
            data_mem[wptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            state_q     <= IDLE;
            dirty_q     <= 1'b0;
            err_q       <= 1'b0;
            commit_q    <= 1'b0;
            sh_period_q <= '1;
            sh_en_q     <= '0;
            sh_duty_q   <= '0;
            period_q    <= '1;
            en_q        <= '0;
            duty_q      <= '0;
        end else begin
            commit_q <= 1'b0;
            err_q    <= err_d;
            if (push) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop) begin
                rptr_q <= rptr_q + (AW+1)'(1);
                if (pop_addr == 4'h0) sh_period_q <= pop_data;
                if (pop_addr == 4'h1) sh_en_q <= NCH'(pop_data);
                for (int i = 0; i < NCH; i++)
                    if (pop_addr == 4'(i + 2)) sh_duty_q[i*DW +: DW] <= pop_data;
                if (is_data) dirty_q <= 1'b1;
                if (pop_addr == 4'hF && dirty_q) state_q <= ARMED;
            end
            if (state_q == ARMED && period_end) begin
                period_q <= sh_period_q;
                en_q     <= sh_en_q;
                duty_q   <= sh_duty_q;
                dirty_q  <= 1'b0;
                commit_q <= 1'b1;
                state_q  <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// tb_pwm_cfg_sequencer: scoreboard bench; a shadow model snapshots the expected
// config on each COMMIT and the commit monitor pops and compares it.
module tb_pwm_cfg_sequencer;
    localparam int NCH = 4, DW = 8, DEPTH = 4;

    typedef struct {
        logic [DW-1:0]     p;
        logic [NCH-1:0]    e;
        logic [NCH*DW-1:0] d;
    } cfg_t;

    logic clk = 0, rst = 1, wr_valid = 0, period_end = 0, clr_err = 0;
    logic [3:0] wr_addr = 0;
    logic [DW-1:0] wr_data = 0;
    logic wr_ready, commit, busy, err;
    logic [DW-1:0] cfg_period;
    logic [NCH*DW-1:0] cfg_duty;
    logic [NCH-1:0] cfg_en;

    int n_total = 0, n_pass = 0, commit_cnt = 0, c0;
    cfg_t exp_q[$];
    cfg_t act, m;
    bit m_dirty;

    pwm_cfg_sequencer #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .period_end(period_end),
        .clr_err(clr_err), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
        .cfg_en(cfg_en), .commit(commit), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        m.p = '1; m.e = '0; m.d = '0; m_dirty = 0;
        act = m;
        exp_q.delete();
    endtask

    task automatic model_wr(input logic [3:0] a, input logic [DW-1:0] d);
        if (a == 4'h0) begin m.p = d; m_dirty = 1; end
        else if (a == 4'h1) begin m.e = d[NCH-1:0]; m_dirty = 1; end
        else if (a >= 4'h2 && a < 4'(NCH + 2)) begin m.d[(a-2)*DW +: DW] = d; m_dirty = 1; end
        else if (a == 4'hF && m_dirty) begin exp_q.push_back(m); m_dirty = 0; end
    endtask

    // called and returns one time unit after a rising edge
    task automatic wr(input logic [3:0] a, input logic [DW-1:0] d);
        bit ok = 0;
        model_wr(a, d);
        wr_valid = 1; wr_addr = a; wr_data = d;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk); ok = wr_ready;
            @(posedge clk); #1;
        end
        wr_valid = 0;
        if (!ok) chk("wr_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_pe();
        period_end = 1; @(posedge clk); #1; period_end = 0;
    endtask

    task automatic chk_act(input string tag);
        @(negedge clk);
        chk({tag, "_period"}, 32'(cfg_period), 32'(act.p));
        chk({tag, "_en"}, 32'(cfg_en), 32'(act.e));
        chk({tag, "_duty"}, cfg_duty, act.d);
    endtask

    always @(negedge clk) begin
        if (commit) begin
            cfg_t e;
            commit_cnt++;
            if (exp_q.size() == 0) chk("unexpected_commit", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("sb_period", 32'(cfg_period), 32'(e.p));
                chk("sb_en", 32'(cfg_en), 32'(e.e));
                chk("sb_duty", cfg_duty, e.d);
                act = e;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst = 1; idle(2); rst = 0;
        @(negedge clk);
        chk("rst_period", 32'(cfg_period), 32'hFF);
        chk("rst_duty", cfg_duty, 0);
        chk("rst_en", 32'(cfg_en), 0);
        chk("rst_commit", 32'(commit), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(wr_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;

        // basic batch
        wr(4'h0, 8'h80); wr(4'h1, 8'h05); wr(4'h3, 8'h40); wr(4'hF, 8'h00);
        idle(10);
        @(negedge clk);
        chk("armed_busy", 32'(busy), 1);
        chk("no_early_commit", commit_cnt, 0);
        @(posedge clk); #1;
        pulse_pe();
        @(negedge clk); chk("basic_commit", 32'(commit), 1);
        @(posedge clk); #1; idle(3);
        chk("basic_one_commit", commit_cnt, 1);
        chk_act("basic");
        chk("basic_val", {cfg_period, 20'(cfg_en), cfg_duty[15:8]}, {8'h80, 20'h5, 8'h40});
        @(posedge clk); #1;

        // atomicity: no COMMIT means no change
        c0 = commit_cnt;
        wr(4'h0, 8'h20); wr(4'h2, 8'h11); wr(4'h1, 8'h0F); wr(4'h2, 8'h12);
        idle(3);
        repeat (3) begin pulse_pe(); idle(2); end
        chk("atom_no_commit", commit_cnt, c0);
        chk_act("atom_hold");
        @(posedge clk); #1;
        wr(4'hF, 8'h00); idle(3); pulse_pe(); idle(2);
        chk("atom_commit", commit_cnt, c0 + 1);
        chk("atom_last_wins", 32'(cfg_duty[7:0]), 32'h12);

        // period_end coinciding with the COMMIT pop is ignored
        c0 = commit_cnt;
        wr(4'h4, 8'h22); idle(4);
        wr(4'hF, 8'h00);
        period_end = 1; @(posedge clk); #1; period_end = 0;
        @(negedge clk); chk("coinc_no_commit", 32'(commit), 0);
        @(posedge clk); #1; idle(5);
        @(negedge clk);
        chk("coinc_cnt", commit_cnt, c0);
        chk("coinc_armed", 32'(busy), 1);
        @(posedge clk); #1;
        pulse_pe();
        @(negedge clk); chk("coinc_late_commit", 32'(commit), 1);
        @(posedge clk); #1; idle(2);

        // COMMIT with nothing dirty never arms
        c0 = commit_cnt;
        wr(4'hF, 8'h00); idle(3);
        @(negedge clk); chk("clean_idle", 32'(busy), 0);
        @(posedge clk); #1;
        pulse_pe(); idle(2);
        chk("clean_no_commit", commit_cnt, c0);

        // backpressure while ARMED
        c0 = commit_cnt;
        wr(4'h0, 8'h33); wr(4'hF, 8'h00); idle(3);
        wr(4'h1, 8'h0A); wr(4'h2, 8'hA2); wr(4'h3, 8'hA3); wr(4'h4, 8'hA4);
        @(negedge clk); chk("bp_full", 32'(wr_ready), 0);
        @(posedge clk); #1;
        fork
            wr(4'h5, 8'h55);
            begin
                repeat (3) begin @(negedge clk); chk("bp_held", 32'(wr_ready), 0); @(posedge clk); #1; end
                pulse_pe();
            end
        join
        idle(6);
        chk("bp_commit", commit_cnt, c0 + 1);
        @(negedge clk); chk("bp_drained", 32'(busy), 0);
        @(posedge clk); #1;
        wr(4'hF, 8'h00); idle(3); pulse_pe(); idle(2);
        chk("bp_commit2", commit_cnt, c0 + 2);
        chk("bp_fifth", 32'(cfg_duty[31:24]), 32'h55);

        // error handling
        @(negedge clk); chk("err_clear0", 32'(err), 0);
        @(posedge clk); #1;
        wr(4'h9, 8'h01); idle(2);
        @(negedge clk); chk("err_set", 32'(err), 1);
        @(posedge clk); #1;
        chk_act("err_outs");
        @(posedge clk); #1;
        wr(4'hA, 8'h02);
        clr_err = 1; @(posedge clk); #1; clr_err = 0;
        @(negedge clk); chk("err_set_wins", 32'(err), 1);
        @(posedge clk); #1;
        clr_err = 1; @(posedge clk); #1; clr_err = 0;
        @(negedge clk); chk("err_cleared", 32'(err), 0);
        @(posedge clk); #1;

        // reset while ARMED discards everything
        c0 = commit_cnt;
        wr(4'h0, 8'h77); wr(4'h1, 8'h03); wr(4'hF, 8'h00); idle(3);
        rst = 1; @(posedge clk); #1; rst = 0;
        model_reset();
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_ready", 32'(wr_ready), 1);
        @(posedge clk); #1;
        chk_act("mrst");
        @(posedge clk); #1;
        pulse_pe(); idle(3);
        chk("mrst_no_commit", commit_cnt, c0);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
